mux_2x1_reg: RTL and testbench
==============================

// Module: mux_2x1_reg
// PURPOSE
//  Registered N:1 data multiplexer (default 4 inputs x 1 bit), the standard
//  selector primitive of the datapath. One input lane is chosen by an unsigned
//  select code and driven out one clock later, with a valid qualifier.
//  Out-of-range selects (non-power-of-2 N) are flagged, never silently aliased.
// PARAMETERS
//  N      4   number of input lanes, 2..16
//  W      1   width of each lane in bits, 1..64
//  SEL_W  $clog2(N) (localparam)  select width
// PORTS
//  clk        in   1      rising-edge clock, the block's only clock
//  rst_n      in   1      synchronous, active-low reset
//  i          in   N*W    packed lanes; lane k = i[k*W +: W]
//  s          in   SEL_W  select code, unsigned, MSB-first value
//  in_valid   in   1      i/s qualified this cycle
//  y          out  W      selected lane, registered
//  out_valid  out  1      y updated this cycle
//  sel_err    out  1      s >= N at last accepted sample
//  y_par      out  1      even parity of y (only with MUX_2X1_REG_PARITY_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): y=0, out_valid=0, sel_err=0, y_par=0.
//    Synchronous only; rst_n low between edges has no effect until next edge.
//  - Select decode: lane index = integer value of s (s=2'b01 -> lane 1,
//    s=2'b10 -> lane 2). Decode is purely combinational into the output regs.
//  - Latency 1: posedge with in_valid=1 and rst_n=1 loads y <= lane[s],
//    out_valid <= 1, sel_err <= (s >= N).
//  - in_valid=0: y, sel_err hold previous values; out_valid <= 0.
//  - Out-of-range s (s >= N): y <= 0, sel_err <= 1, out_valid <= 1.
//  - Back-to-back valid samples: one result per cycle, no bubbles, no stall.
//  - Reset takes priority over a simultaneous in_valid; the sample is dropped.
//  - Change of i or s without in_valid never disturbs y.
//  - No X propagation: unknown s is treated as out-of-range by the decoder.
// CONFIGURATION
//  MUX_2X1_REG_PARITY_EN defined: y_par port present; y_par registered with y,
//    y_par <= ^lane[s] (0 on out-of-range or reset); holds when in_valid=0.
//  Not defined: y_par port absent; all other behaviour identical.
// STRUCTURE
//  - Package mux_pkg: MUX_MAX_N=16, MUX_MAX_W=64 limits, function
//    sel_in_range(s,N), typedef for select code of max width.
//  - Sub-module mux_sel_comb (combinational): i, s -> lane, in_range.
//    Top level holds only the output registers, reset and valid logic.
//  - Elaboration-time check: error if N<2, N>16, W<1 or W>64.
// TESTING
//  1. rst_n=0 two cycles, in_valid=1 -> y=0, out_valid=0, sel_err=0.
//  2. N=4,W=1: s=00 i=0101, s=01 i=0110, s=10 i=0111, s=11 i=1101 on
//     consecutive valid cycles -> y=1 each, one cycle later, out_valid=1.
//  3. s=10, i=1011 valid then in_valid=0 with i=0000 -> y stays 0 then holds 0;
//     swap to s=11 i=1000 valid -> y=1 next cycle; out_valid 1,0,1 pattern.
//  4. N=3,W=8: s=11 valid -> y=8'h00, sel_err=1; then s=01 lane1=8'hA5
//     -> y=8'hA5, sel_err=0.
//  5. Valid sample at same edge as rst_n=0 -> y=0, out_valid=0; next valid
//     sample after release -> correct lane.
//  6. With MUX_2X1_REG_PARITY_EN, W=8, lane=8'h07 -> y_par=1; 8'h03 -> 0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared limits, select type and range helper for the registered lane mux
package mux_pkg;
   localparam int MUX_MAX_N = 16;
   localparam int MUX_MAX_W = 64;
   localparam int MUX_MAX_SEL_W = $clog2(MUX_MAX_N);
   typedef logic [MUX_MAX_SEL_W-1:0] mux_sel_t;
   function automatic logic sel_in_range(input mux_sel_t s, input int unsigned n);
      return 32'(s) < n;
   endfunction
endpackage

// File: rtl/mux_sel_comb.sv
// mux_sel_comb: combinational lane select with range flag; unknown or out-of-range s gives lane 0 and in_range 0
module mux_sel_comb
   import mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 1,
   localparam int SEL_W = $clog2(N)
) (
   input  logic [N*W-1:0] i,
   input  logic [SEL_W-1:0] s,
   output logic [W-1:0] lane,
   output logic in_range
);
   mux_sel_t s_ext;
   assign s_ext = MUX_MAX_SEL_W'(s);
   // an X select matches no lane and fails the range test, so it lands on the out-of-range path
   always_comb begin
      lane = '0;
      in_range = 1'b0;
      if (sel_in_range(s_ext, N)) in_range = 1'b1;
      for (int k = 0; k < N; k++)
         if (s == SEL_W'(k)) lane = i[k*W +: W];
   end
endmodule

// File: rtl/mux_2x1_reg.sv
// mux_2x1_reg: registered N:1 lane mux with valid and select-error flags; optional y_par via MUX_2X1_REG_PARITY_EN
module mux_2x1_reg
   import mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 1,
   localparam int SEL_W = $clog2(N)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [N*W-1:0] i,
   input  logic [SEL_W-1:0] s,
   input  logic in_valid,
   output logic [W-1:0] y,
   output logic out_valid,
   output logic sel_err
`ifdef MUX_2X1_REG_PARITY_EN
   ,output logic y_par
`endif
);
   logic [W-1:0] lane;
   logic in_range;
   if (N < 2 || N > MUX_MAX_N || W < 1 || W > MUX_MAX_W) begin : g_bad_cfg
      $error("mux_2x1_reg: N must be 2..16 and W 1..64");
   end
   mux_sel_comb #(.N(N), .W(W)) u_sel (
      .i(i),
      .s(s),
      .lane(lane),
      .in_range(in_range)
   );
   // capture the selected lane on each accepted sample; out-of-range already yields lane 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y <= '0;
         out_valid <= 1'b0;
         sel_err <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y <= lane;
            sel_err <= ~in_range;
         end
      end
   end
`ifdef MUX_2X1_REG_PARITY_EN
   // parity tracks y exactly, so it shares the same load and hold conditions
   always_ff @(posedge clk) begin
      if (!rst_n) y_par <= 1'b0;
      else if (in_valid) y_par <= ^lane;
   end
`endif
endmodule

// File: tb/tb_mux_2x1_reg.sv
// tb_mux_2x1_reg: directed checks of the registered lane mux at N=4/W=1 and N=3/W=8
module tb_mux_2x1_reg;
   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] i4;
   logic [1:0] s4;
   logic v4;
   logic y4, ov4, se4;
   logic [23:0] i3;
   logic [1:0] s3;
   logic v3;
   logic [7:0] y3;
   logic ov3, se3;
`ifdef MUX_2X1_REG_PARITY_EN
   logic yp4, yp3;
`endif
   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mux_2x1_reg #(.N(4), .W(1)) u4 (
      .clk(clk), .rst_n(rst_n), .i(i4), .s(s4), .in_valid(v4),
      .y(y4), .out_valid(ov4), .sel_err(se4)
`ifdef MUX_2X1_REG_PARITY_EN
      , .y_par(yp4)
`endif
   );

   mux_2x1_reg #(.N(3), .W(8)) u3 (
      .clk(clk), .rst_n(rst_n), .i(i3), .s(s3), .in_valid(v3),
      .y(y3), .out_valid(ov3), .sel_err(se3)
`ifdef MUX_2X1_REG_PARITY_EN
      , .y_par(yp3)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      i4 = 4'b1111; s4 = 2'd1; v4 = 1'b1;
      i3 = 24'hFFFFFF; s3 = 2'd1; v3 = 1'b1;
      tick();
      tick();
      chk("rst_y4", y4, 0);
      chk("rst_ov4", ov4, 0);
      chk("rst_se4", se4, 0);
      chk("rst_y3", y3, 0);
      chk("rst_ov3", ov3, 0);
      chk("rst_se3", se3, 0);
      rst_n = 1'b1;
      v3 = 1'b0;
      s4 = 2'd0; i4 = 4'b0101;
      tick();
      chk("l0_y", y4, 1);
      chk("l0_ov", ov4, 1);
      chk("l0_se", se4, 0);
      s4 = 2'd1; i4 = 4'b0110;
      tick();
      chk("l1_y", y4, 1);
      chk("l1_ov", ov4, 1);
      s4 = 2'd2; i4 = 4'b0111;
      tick();
      chk("l2_y", y4, 1);
      s4 = 2'd3; i4 = 4'b1101;
      tick();
      chk("l3_y", y4, 1);
      chk("l3_ov", ov4, 1);
      v4 = 1'b0; i4 = 4'b0000; s4 = 2'd0;
      tick();
      chk("hold1_y", y4, 1);
      chk("hold1_ov", ov4, 0);
      v4 = 1'b1; s4 = 2'd2; i4 = 4'b1011;
      tick();
      chk("s10_y", y4, 0);
      chk("s10_ov", ov4, 1);
      v4 = 1'b0; i4 = 4'b1111; s4 = 2'd0;
      tick();
      chk("hold0_y", y4, 0);
      chk("hold0_ov", ov4, 0);
      v4 = 1'b1; s4 = 2'd3; i4 = 4'b1000;
      tick();
      chk("s11_y", y4, 1);
      chk("s11_ov", ov4, 1);
      v4 = 1'b0;
      v3 = 1'b1; s3 = 2'd3; i3 = 24'hFFFFFF;
      tick();
      chk("oor_y", y3, 8'h00);
      chk("oor_se", se3, 1);
      chk("oor_ov", ov3, 1);
      v3 = 1'b0; s3 = 2'd1;
      tick();
      chk("oor_hold_se", se3, 1);
      chk("oor_hold_ov", ov3, 0);
      v3 = 1'b1; s3 = 2'd1; i3 = {8'h11, 8'hA5, 8'h3C};
      tick();
      chk("w8_l1_y", y3, 8'hA5);
      chk("w8_l1_se", se3, 0);
      s3 = 2'd2;
      tick();
      chk("w8_l2_y", y3, 8'h11);
      s3 = 2'd0;
      tick();
      chk("w8_l0_y", y3, 8'h3C);
      v3 = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("async_no_y3", y3, 8'h3C);
      rst_n = 1'b1;
      v4 = 1'b1; s4 = 2'd3; i4 = 4'b1000;
      tick();
      chk("pre_rst_y", y4, 1);
      rst_n = 1'b0; s4 = 2'd3; i4 = 4'b1000;
      tick();
      chk("rst_pri_y", y4, 0);
      chk("rst_pri_ov", ov4, 0);
      rst_n = 1'b1; s4 = 2'd0; i4 = 4'b0001;
      tick();
      chk("post_rst_y", y4, 1);
      chk("post_rst_ov", ov4, 1);
`ifdef MUX_2X1_REG_PARITY_EN
      v4 = 1'b0;
      v3 = 1'b1; s3 = 2'd1; i3 = {8'h00, 8'h07, 8'h00};
      tick();
      chk("par07", yp3, 1);
      i3 = {8'h00, 8'h03, 8'h00};
      tick();
      chk("par03", yp3, 0);
      v3 = 1'b0; i3 = {8'h00, 8'h01, 8'h00};
      tick();
      chk("par_hold", yp3, 0);
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
